// File: rtl/controlador_es_if.sv
// CPU-side handshake for the I/O controller: instruction strobes and output
// data come from the processor, and cpu_enable goes back to it as the stall line.
interface controlador_es_if;
    logic        OpIn;
    logic        OpOut;
    logic        OpHalt;
    logic [27:0] dado_saida;
    logic        cpu_enable;

    modport master (
        output OpIn,
        output OpOut,
        output OpHalt,
        output dado_saida,
        input  cpu_enable
    );

    modport slave (
        input  OpIn,
        input  OpOut,
        input  OpHalt,
        input  dado_saida,
        output cpu_enable
    );
endinterface

// File: rtl/controlador_es.sv
// I/O responder for the single-cycle CPU. IN stalls until a debounced key
// press and release, OUT latches a 28-bit value shown on four 7-segment
// digits, and HALT freezes the CPU until reset.
module controlador_es #(
    parameter int unsigned                DEBOUNCE_W   = 16,
    parameter logic [DEBOUNCE_W-1:0]      DEBOUNCE_MAX = 16'd50000
) (
    input  logic                clock,
    input  logic                reset_n,
    controlador_es_if.slave     cpu,
    input  logic                botao,
    output logic [27:0]         valor_saida,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2,
    output logic [6:0]          hex3,
    output logic                aguardando,
    output logic                parado
);

    typedef enum logic [2:0] {
        EXEC,
        ESPERA_PRESS,
        ESPERA_SOLTA,
        LIBERA,
        PARADO
    } state_t;

    // Count value reached after DEBOUNCE_MAX-1 matching cycles; one more
    // matching cycle completes the debounce window.
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_MAX - 1'b1;

    state_t                 state;
    logic                   botao_m;
    logic                   botao_s;
    logic [DEBOUNCE_W-1:0]  cnt;

    // Two-flop synchronizer for the asynchronous key; idle level is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            botao_m <= 1'b1;
            botao_s <= 1'b1;
        end else begin
            botao_m <= botao;
            botao_s <= botao_m;
        end
    end

    // Controller FSM with debounce counter, OUT latch and registered status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EXEC;
            cnt         <= '0;
            valor_saida <= '0;
            aguardando  <= 1'b0;
            parado      <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    if (cpu.OpHalt) begin
                        state  <= PARADO;
                        parado <= 1'b1;
                    end else if (cpu.OpIn) begin
                        state      <= ESPERA_PRESS;
                        aguardando <= 1'b1;
                        cnt        <= '0;
                    end else if (cpu.OpOut) begin
                        valor_saida <= cpu.dado_saida;
                    end
                end
                ESPERA_PRESS: begin
                    if (!botao_s) begin
                        if (cnt == CNT_LAST) begin
                            state <= ESPERA_SOLTA;
                            cnt   <= '0;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                ESPERA_SOLTA: begin
                    if (botao_s) begin
                        if (cnt == CNT_LAST) begin
                            state      <= LIBERA;
                            aguardando <= 1'b0;
                            cnt        <= '0;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                LIBERA: begin
                    state <= EXEC;
                end
                PARADO: begin
                    state <= PARADO;
                end
                default: begin
                    state      <= EXEC;
                    cnt        <= '0;
                    aguardando <= 1'b0;
                    parado     <= 1'b0;
                end
            endcase
        end
    end

    // Stall line must react to OpIn/OpHalt within the same cycle.
    always_comb begin
        cpu.cpu_enable = 1'b0;
        case (state)
            EXEC:    cpu.cpu_enable = ~cpu.OpIn & ~cpu.OpHalt;
            LIBERA:  cpu.cpu_enable = 1'b1;
            default: cpu.cpu_enable = 1'b0;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Active-low digit patterns decoded from the latched output value.
    always_comb begin
        hex0 = seg7(valor_saida[3:0]);
        hex1 = seg7(valor_saida[7:4]);
        hex2 = seg7(valor_saida[11:8]);
        hex3 = seg7(valor_saida[15:12]);
    end

endmodule

// File: tb/tb_controlador_es.sv
// Scoreboard bench for controlador_es with DEBOUNCE_MAX=4. The driver predicts
// OUT values and IN release cycles from the key waveform; a monitor compares
// them whenever the DUT accepts an OUT or releases a stalled IN.
module tb_controlador_es;

    localparam int DM = 4;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clock = 1'b0;
    logic        reset_n;
    logic        botao;
    logic [27:0] valor_saida;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        aguardando, parado;

    controlador_es_if cpu();

    controlador_es #(
        .DEBOUNCE_W   (16),
        .DEBOUNCE_MAX (16'd4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu         (cpu),
        .botao       (botao),
        .valor_saida (valor_saida),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .aguardando  (aguardando),
        .parado      (parado)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          exp_rel_q[$];
    logic [27:0] exp_out_q[$];
    logic [27:0] model_out;
    logic        rel_seen;
    logic        out_fire;
    logic        prev1, prev2;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Start a driver cycle just after the rising edge and drive the raw key.
    task automatic next_cycle(input logic k);
        @(posedge clock);
        #1;
        botao = k;
        prev2 = prev1;
        prev1 = k;
    endtask

    task automatic do_reset();
        cpu.OpIn = 1'b0; cpu.OpOut = 1'b0; cpu.OpHalt = 1'b0;
        botao = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        prev1 = 1'b1; prev2 = 1'b1;
        model_out = '0;
        exp_rel_q.delete();
        exp_out_q.delete();
    endtask

    // One OUT instruction in EXEC; the monitor checks the latched value.
    task automatic do_out(input logic [27:0] d);
        next_cycle(1'b1);
        cpu.OpIn = 1'b0; cpu.OpHalt = 1'b0;
        cpu.OpOut = 1'b1; cpu.dado_saida = d;
        exp_out_q.push_back(d);
        model_out = d;
        @(negedge clock); #1;
        chk("out_cpu_enable", {31'd0, cpu.cpu_enable}, 32'd1);
        next_cycle(1'b1);
        cpu.OpOut = 1'b0;
    endtask

    // One IN instruction with raw key waveform kp (cycle 0 = OpIn rises).
    // Release cycle is derived from the synchronized key: first run of DM
    // lows seen while waiting for press, then DM highs while waiting for release.
    task automatic do_in(input logic kp[$], input bit hold_after);
        logic bs[200];
        int   p, r, rel, start, t;
        bit   ok, timed_out;
        for (int i = 0; i < 200; i++) begin
            if (i == 0)                bs[i] = prev2;
            else if (i == 1)           bs[i] = prev1;
            else if (i - 2 < kp.size()) bs[i] = kp[i-2];
            else                       bs[i] = 1'b1;
        end
        p = -1;
        for (int i = DM; i < 200 && p < 0; i++) begin
            ok = 1;
            for (int j = 0; j < DM; j++) if (bs[i-j] != 1'b0) ok = 0;
            if (ok) p = i;
        end
        r = -1;
        for (int i = p + DM; p >= 0 && i < 200 && r < 0; i++) begin
            ok = 1;
            for (int j = 0; j < DM; j++) if (bs[i-j] != 1'b1) ok = 0;
            if (ok) r = i;
        end
        if (r < 0) begin
            $display("FAIL in_model: key pattern never resolves, got %0d expected >0", r);
            $fatal(1);
        end
        rel = r + 1;
        timed_out = 0;
        t = 0;
        next_cycle((kp.size() > 0) ? kp[0] : 1'b1);
        start = cyc;
        rel_seen = 1'b0;
        exp_rel_q.push_back(start + rel);
        cpu.OpIn = 1'b1; cpu.OpHalt = 1'b0;
        cpu.OpOut = 1'($urandom_range(0, 1));
        cpu.dado_saida = 28'($urandom);
        forever begin
            @(negedge clock); #1;
            if (t == 0) chk("in_stall_same_cycle", {31'd0, cpu.cpu_enable}, 32'd0);
            chk("in_aguardando", {31'd0, aguardando}, {31'd0, (t >= 1 && t <= r)});
            if (rel_seen) break;
            if (t > rel + 8) begin
                timed_out = 1;
                checks++; fails++;
                $display("FAIL in_release_timeout: got none expected release at cycle %0d", rel);
                break;
            end
            t++;
            next_cycle((t < kp.size()) ? kp[t] : 1'b1);
            cpu.OpOut = 1'($urandom_range(0, 1));
            cpu.dado_saida = 28'($urandom);
        end
        if (timed_out) begin
            do_reset();
            return;
        end
        next_cycle(1'b1);
        cpu.OpOut = 1'b0;
        if (hold_after) begin
            @(negedge clock); #1;
            chk("in_single_libera", {31'd0, cpu.cpu_enable}, 32'd0);
            next_cycle(1'b1);
            @(negedge clock); #1;
            chk("in_rearm_aguardando", {31'd0, aguardando}, 32'd1);
            do_reset();
        end else begin
            cpu.OpIn = 1'b0;
            @(negedge clock); #1;
            chk("in_valor_unchanged", {4'd0, valor_saida}, {4'd0, model_out});
        end
    endtask

    task automatic rand_in();
        logic kp[$];
        int   n;
        n = $urandom_range(0, 2);
        repeat (n) kp.push_back(1'b1);
        n = $urandom_range(0, 2);
        repeat (n) begin
            repeat ($urandom_range(1, 3)) kp.push_back(1'b0);
            repeat ($urandom_range(1, 2)) kp.push_back(1'b1);
        end
        repeat ($urandom_range(DM, DM + 3)) kp.push_back(1'b0);
        n = $urandom_range(0, 2);
        repeat (n) begin
            repeat ($urandom_range(1, 3)) kp.push_back(1'b1);
            repeat ($urandom_range(1, 2)) kp.push_back(1'b0);
        end
        do_in(kp, 1'b0);
    endtask

    // Scoreboard monitor: OUT acceptance and IN release are the output events.
    initial begin
        int          e;
        logic [27:0] v;
        out_fire = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                out_fire = 1'b0;
            end else begin
                if (out_fire) begin
                    if (exp_out_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL out_unexpected: got %0h expected no OUT latch", valor_saida);
                    end else begin
                        v = exp_out_q.pop_front();
                        chk("out_valor", {4'd0, valor_saida}, {4'd0, v});
                        chk("out_hex0", {25'd0, hex0}, {25'd0, SEG[v[3:0]]});
                        chk("out_hex1", {25'd0, hex1}, {25'd0, SEG[v[7:4]]});
                        chk("out_hex2", {25'd0, hex2}, {25'd0, SEG[v[11:8]]});
                        chk("out_hex3", {25'd0, hex3}, {25'd0, SEG[v[15:12]]});
                    end
                end
                out_fire = cpu.OpOut & cpu.cpu_enable & ~cpu.OpIn;
                if (cpu.OpIn && cpu.cpu_enable) begin
                    rel_seen = 1'b1;
                    if (exp_rel_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL in_unexpected_release: got release at cycle %0d expected none", cyc);
                    end else begin
                        e = exp_rel_q.pop_front();
                        chk("in_release_cycle", cyc, e);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        logic kp[$];
        cpu.OpIn = 1'b0; cpu.OpOut = 1'b0; cpu.OpHalt = 1'b0;
        cpu.dado_saida = '0;
        botao = 1'b1; prev1 = 1'b1; prev2 = 1'b1;
        rel_seen = 1'b0;
        model_out = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clock); #1;
        chk("rst_cpu_enable", {31'd0, cpu.cpu_enable}, 32'd1);
        chk("rst_valor", {4'd0, valor_saida}, 32'd0);
        chk("rst_hex0", {25'd0, hex0}, 32'b1000000);
        chk("rst_hex3", {25'd0, hex3}, 32'b1000000);
        chk("rst_aguardando", {31'd0, aguardando}, 32'd0);
        chk("rst_parado", {31'd0, parado}, 32'd0);

        // Directed OUT with known digit patterns
        do_out(28'h000A5F1);
        @(negedge clock); #1;
        chk("dir_hex3_A", {25'd0, hex3}, 32'b0001000);
        chk("dir_hex2_5", {25'd0, hex2}, 32'b0010010);
        chk("dir_hex1_F", {25'd0, hex1}, 32'b0001110);
        chk("dir_hex0_1", {25'd0, hex0}, 32'b1111001);

        // Clean key: 10 lows then release, OpIn held after the release
        kp.delete();
        repeat (10) kp.push_back(1'b0);
        do_in(kp, 1'b1);

        // Bouncing press and release
        kp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_in(kp, 1'b0);

        // Key already held before OpIn rises
        repeat (5) next_cycle(1'b0);
        kp = '{1'b0, 1'b0, 1'b0};
        do_in(kp, 1'b0);

        // HALT together with IN, then OUT attempts are ignored
        do_out(28'h0BEEF42);
        next_cycle(1'b1);
        cpu.OpIn = 1'b1; cpu.OpHalt = 1'b1;
        @(negedge clock); #1;
        chk("halt_same_cycle", {31'd0, cpu.cpu_enable}, 32'd0);
        next_cycle(1'b1);
        cpu.OpIn = 1'b0; cpu.OpHalt = 1'b0;
        cpu.OpOut = 1'b1; cpu.dado_saida = 28'h1234567;
        @(negedge clock); #1;
        chk("halt_parado", {31'd0, parado}, 32'd1);
        chk("halt_cpu_enable", {31'd0, cpu.cpu_enable}, 32'd0);
        repeat (3) next_cycle(1'b1);
        @(negedge clock); #1;
        chk("halt_valor_held", {4'd0, valor_saida}, {4'd0, model_out});
        chk("halt_still_parado", {31'd0, parado}, 32'd1);
        do_reset();
        @(negedge clock); #1;
        chk("halt_reset_parado", {31'd0, parado}, 32'd0);

        // Reset asserted while waiting for release
        do_out(28'h0000777);
        next_cycle(1'b0);
        cpu.OpIn = 1'b1;
        repeat (7) next_cycle(1'b0);
        repeat (2) next_cycle(1'b1);
        @(negedge clock); #1;
        chk("midstall_aguardando", {31'd0, aguardando}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midstall_async_aguardando", {31'd0, aguardando}, 32'd0);
        chk("midstall_valor", {4'd0, valor_saida}, 32'd0);
        chk("midstall_hex0", {25'd0, hex0}, 32'b1000000);
        cpu.OpIn = 1'b0;
        #1;
        chk("midstall_cpu_enable", {31'd0, cpu.cpu_enable}, 32'd1);
        @(posedge clock); #1 reset_n = 1'b1;
        prev1 = 1'b1; prev2 = 1'b1; botao = 1'b1;
        model_out = '0;

        // Randomized mix of NOP, OUT and IN
        for (int unsigned i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    next_cycle(1'b1);
                    cpu.OpIn = 1'b0; cpu.OpOut = 1'b0; cpu.OpHalt = 1'b0;
                end
                1: do_out(28'($urandom));
                default: rand_in();
            endcase
        end

        repeat (3) next_cycle(1'b1);
        @(negedge clock); #1;
        chk("final_out_queue_empty", exp_out_q.size(), 32'd0);
        chk("final_rel_queue_empty", exp_rel_q.size(), 32'd0);
        chk("final_valor", {4'd0, valor_saida}, {4'd0, model_out});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
